bcd_conv_arbiter: RTL and testbench

//  Shares one binary-to-BCD conversion datapath (tens = v/10, units = v%10) among

---
 rtl/clock_pkg.sv | 20 ++
 rtl/rr_pick.sv | 27 ++
 rtl/bcd_conv_arbiter.sv | 84 ++++++++
 tb/tb_bcd_conv_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock BCD conversion path.
package clock_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, CONV, DONE} state_t;

  localparam logic [7:0] BCD_SAT = 8'h99;
  localparam int         BCD_MAX = 99;

  localparam int REQ_SEC   = 0;
  localparam int REQ_MIN   = 1;
  localparam int REQ_HOUR  = 2;
  localparam int REQ_ALARM = 3;

  // Two-digit packed BCD; anything above 99 saturates to 99.
  function automatic logic [7:0] to_bcd(input logic [15:0] v);
    if (v > 16'(BCD_MAX)) return BCD_SAT;
    return {4'(v / 16'd10), 4'(v % 16'd10)};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req scanning upward from ptr.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant,
  output logic            any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
      idx = (idx == ID_W'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// One binary-to-BCD converter shared round-robin between the clock's counters,
// with a req/ack handshake and a registered, id-tagged result.
module bcd_conv_arbiter
  import clock_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int BIN_W = 7,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*BIN_W-1:0] data_in,
  output logic [NREQ-1:0]       ack,
  output logic [7:0]            data_out,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_valid,
  output logic                  err
);

  state_t           state_reg;
  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  winner_reg;
  logic [BIN_W-1:0] op_reg;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [BIN_W-1:0] ops [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ops
      assign ops[gi] = data_in[gi*BIN_W +: BIN_W];
    end
  endgenerate

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .grant (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      winner_reg <= '0;
      op_reg     <= '0;
      ack        <= '0;
      out_valid  <= 1'b0;
      data_out   <= 8'h00;
      out_id     <= '0;
      err        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            winner_reg <= pick_idx;
            op_reg     <= ops[pick_idx];
            state_reg  <= GRANT;
          end
        end
        GRANT: state_reg <= CONV;
        CONV: begin
          // Results land here so ack/out_valid are high exactly during DONE.
          data_out  <= to_bcd(16'(op_reg));
          err       <= (16'(op_reg) > 16'(BCD_MAX));
          out_id    <= winner_reg;
          ack       <= NREQ'(1) << winner_reg;
          out_valid <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          ack       <= '0;
          out_valid <= 1'b0;
          ptr_reg   <= (winner_reg == ID_W'(NREQ - 1)) ? '0 : winner_reg + 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a scoreboard of expected results.
module tb_bcd_conv_arbiter;

  localparam int NREQ  = 4;
  localparam int BIN_W = 7;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*BIN_W-1:0] data_in;
  logic [NREQ-1:0]       ack;
  logic [7:0]            data_out;
  logic [ID_W-1:0]       out_id;
  logic                  out_valid;
  logic                  err;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  bcd_conv_arbiter #(.NREQ(NREQ), .BIN_W(BIN_W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .ack       (ack),
    .data_out  (data_out),
    .out_id    (out_id),
    .out_valid (out_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_op(input int i, input int v);
    data_in[i*BIN_W +: BIN_W] = BIN_W'(v);
  endtask

  task automatic push(input int id, input int v);
    exp_t e;
    e.id = id;
    if (v > 99) begin
      e.data = 8'h99;
      e.err  = 1'b1;
    end else begin
      e.data = {4'(v / 10), 4'(v % 10)};
      e.err  = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic check_quiet(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("quiet_ack", 32'(ack), 0);
      check("quiet_valid", 32'(out_valid), 0);
    end
  endtask

  // Wait for one result, compare against the scoreboard head, then release the
  // requesters in drop at the DONE cycle, as a real requester would.
  task automatic expect_result(input int exp_lat, input logic [NREQ-1:0] drop);
    int   n = 0;
    exp_t e;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 12);
    check("result_seen", 32'(out_valid), 1);
    check("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (!out_valid) return;
    if (exp_lat >= 0) check("latency", 32'(n), 32'(exp_lat));
    check("data_out", 32'(data_out), 32'(e.data));
    check("out_id", 32'(out_id), 32'(e.id));
    check("err", 32'(err), 32'(e.err));
    check("ack_onehot", 32'(ack), 32'(1) << e.id);
    $display("[TB] result id=%0d data=%02h err=%0b ack=%b after %0d cycles",
             out_id, data_out, err, ack, n);
    req = req & ~drop;
    @(negedge clk);
    check("ack_pulse", 32'(ack), 0);
    check("valid_pulse", 32'(out_valid), 0);
  endtask

  initial begin
    int bvals[6] = '{0, 9, 10, 99, 100, 127};
    rst     = 1'b1;
    req     = '0;
    data_in = '0;

    // Reset state
    @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_id", 32'(out_id), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single conversion
    set_op(0, 59);
    req[0] = 1'b1;
    push(0, 59);
    expect_result(3, 4'b0001);

    // Boundary operands
    for (int i = 0; i < 6; i++) begin
      set_op(0, bvals[i]);
      req[0] = 1'b1;
      push(0, bvals[i]);
      expect_result(3, 4'b0001);
    end

    // Async reset in CONV discards the capture; held req[1] is redone
    set_op(1, 42);
    req[1] = 1'b1;
    push(1, 42);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_data", 32'(data_out), 0);
    check("midrst_err", 32'(err), 0);
    check("midrst_id", 32'(out_id), 0);
    check("midrst_ack", 32'(ack), 0);
    check("midrst_valid", 32'(out_valid), 0);
    check_quiet(3);
    rst = 1'b0;
    expect_result(3, 4'b0010);

    // Contention from ptr=0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_op(0, 12);
    set_op(1, 34);
    set_op(2, 56);
    set_op(3, 78);
    req = 4'b1111;
    push(0, 12);
    push(1, 34);
    push(2, 56);
    push(3, 78);
    push(0, 12);
    for (int i = 0; i < 4; i++) expect_result(3, 4'b0000);
    expect_result(3, 4'b1111);

    // Fairness: req[0] held throughout, req[2] raised once
    set_op(0, 5);
    set_op(2, 77);
    req[0] = 1'b1;
    push(0, 5);
    expect_result(3, 4'b0000);
    req[2] = 1'b1;
    push(2, 77);
    push(0, 5);
    expect_result(3, 4'b0100);
    expect_result(3, 4'b0001);

    // Operand changes after capture are ignored
    set_op(0, 33);
    req[0] = 1'b1;
    push(0, 33);
    @(negedge clk);
    set_op(0, 88);
    @(negedge clk);
    set_op(0, 120);
    expect_result(1, 4'b0001);

    // req dropped right after capture still completes
    set_op(0, 44);
    req[0] = 1'b1;
    push(0, 44);
    @(negedge clk);
    req[0] = 1'b0;
    expect_result(2, 4'b0000);

    check_quiet(6);
    check("sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
